// File: rtl/seven_segment_pkg.sv
// Shared definitions for the 7-segment display capture block.
//   - Segment patterns for hex digits 0..F (gfedcba order, 1 = segment lit)
//   - Digit slot indices (AN1 = slot 0 ... AN4 = slot 3)
//   - Anode classification type used by the slot decoder
//   - seg_to_hex(): active-high segment vector -> {valid, value[3:0]}
package seven_segment_pkg;

    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_6 = 7'b1111101;
    localparam logic [6:0] SEG_7 = 7'b0000111;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1101111;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b1111100;
    localparam logic [6:0] SEG_C = 7'b0111001;
    localparam logic [6:0] SEG_D = 7'b1011110;
    localparam logic [6:0] SEG_E = 7'b1111001;
    localparam logic [6:0] SEG_F = 7'b1110001;

    localparam logic [1:0] SEC1 = 2'd0;
    localparam logic [1:0] SEC2 = 2'd1;
    localparam logic [1:0] MIN1 = 2'd2;
    localparam logic [1:0] MIN2 = 2'd3;

    typedef enum logic [1:0] {
        ANODE_NONE  = 2'd0,
        ANODE_ONE   = 2'd1,
        ANODE_MULTI = 2'd2
    } anode_class_e;

    // Returns {valid, value}; blank and any non-hex pattern give valid = 0.
    function automatic logic [4:0] seg_to_hex(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            SEG_0:   res = {1'b1, 4'h0};
            SEG_1:   res = {1'b1, 4'h1};
            SEG_2:   res = {1'b1, 4'h2};
            SEG_3:   res = {1'b1, 4'h3};
            SEG_4:   res = {1'b1, 4'h4};
            SEG_5:   res = {1'b1, 4'h5};
            SEG_6:   res = {1'b1, 4'h6};
            SEG_7:   res = {1'b1, 4'h7};
            SEG_8:   res = {1'b1, 4'h8};
            SEG_9:   res = {1'b1, 4'h9};
            SEG_A:   res = {1'b1, 4'hA};
            SEG_B:   res = {1'b1, 4'hB};
            SEG_C:   res = {1'b1, 4'hC};
            SEG_D:   res = {1'b1, 4'hD};
            SEG_E:   res = {1'b1, 4'hE};
            SEG_F:   res = {1'b1, 4'hF};
            default: res = {1'b0, 4'h0};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seven_segment_display_capture_filter.sv
// seven_segment_input_filter
//   Two-flop synchronizer plus stability filter for the 12 display lines.
//   accept pulses for one cycle the first time the synchronized word has been
//   seen STABLE_CYCLES times in a row; it will not fire again until the word
//   changes.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   raw_word     : {AN4..AN1, CG..CA, DP} straight from the pins (active-low)
//   sync_word    : synchronized copy of raw_word (2 cycles of latency)
//   accept       : one-cycle pulse, sync_word is stable and should be used
module seven_segment_input_filter #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] raw_word,
    output logic [11:0] sync_word,
    output logic        accept
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    // accept fires on the transition from ARM to MAX, i.e. exactly once per run
    localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(STABLE_CYCLES - 2);

    logic [11:0]      meta_r;
    logic [11:0]      sync_r;
    logic [11:0]      prev_word_r;
    logic [CNT_W-1:0] stab_cnt_r;
    logic [CNT_W-1:0] stab_cnt_next_s;
    logic             same_s;
    logic             accept_s;

    // Synchronizer; idle level of the active-low lines is all ones
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= 12'hFFF;
            sync_r <= 12'hFFF;
        end else begin
            meta_r <= raw_word;
            sync_r <= meta_r;
        end
    end

    // Run-length counter of the synchronized word and accept detection
    always_comb begin
        stab_cnt_next_s = stab_cnt_r;
        same_s          = (sync_r == prev_word_r);
        if (!same_s) begin
            stab_cnt_next_s = {CNT_W{1'b0}};
        end else if (stab_cnt_r == CNT_MAX) begin
            stab_cnt_next_s = stab_cnt_r;
        end else begin
            stab_cnt_next_s = stab_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        accept_s = same_s && (stab_cnt_r == CNT_ARM);
    end

    // Previous word and stability counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_word_r <= 12'hFFF;
            stab_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            prev_word_r <= sync_r;
            stab_cnt_r  <= stab_cnt_next_s;
        end
    end

    assign sync_word = sync_r;
    assign accept    = accept_s;

endmodule

// File: rtl/seven_segment_display_capture.sv
// seven_segment_display_capture
//   Captures a 4-digit multiplexed 7-segment display bus back into hex digits.
//   Each stable, single-anode slot is decoded into a shadow register; once all
//   four slots have been seen the shadows are published as one coherent frame.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   CA..CG, DP                 : segment / decimal point lines, active-low
//   AN1..AN4                   : anode lines, active-low (AN1 = digit 0)
//   sec_dig1, sec_dig2         : digits 0 and 1
//   min_dig1, min_dig2         : digits 2 and 3
//   decimal_point              : bit i = DP lit during digit i
//   frame_valid                : one-cycle pulse when the digit outputs update
//   seg_error                  : one-cycle pulse, accepted slot not a hex glyph
//   anode_error                : one-cycle pulse, accepted slot had >1 anode low
//   stale                      : no frame completed for TIMEOUT_CYCLES cycles
module seven_segment_display_capture
    import seven_segment_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       CA,
    input  logic       CB,
    input  logic       CC,
    input  logic       CD,
    input  logic       CE,
    input  logic       CF,
    input  logic       CG,
    input  logic       DP,
    input  logic       AN1,
    input  logic       AN2,
    input  logic       AN3,
    input  logic       AN4,
    output logic [3:0] sec_dig1,
    output logic [3:0] sec_dig2,
    output logic [3:0] min_dig1,
    output logic [3:0] min_dig2,
    output logic [3:0] decimal_point,
    output logic       frame_valid,
    output logic       seg_error,
    output logic       anode_error,
    output logic       stale
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

    logic [11:0]     raw_word_s;
    logic [11:0]     sync_word_s;
    logic            accept_s;
    logic [3:0]      an_act_s;
    logic [6:0]      seg_act_s;
    logic            dp_lit_s;
    logic [4:0]      dec_s;
    anode_class_e    an_class_s;
    logic [1:0]      digit_idx_s;
    logic [3:0]      accept_bit_s;
    logic            seg_err_s;
    logic            an_err_s;
    logic            complete_s;
    logic [3:0]      mask_next_s;
    logic [TO_W-1:0] to_cnt_next_s;

    logic [3:0]      mask_r;
    logic [3:0]      shadow_r [4];
    logic [3:0]      dp_shadow_r;
    logic [3:0]      digit_out_r [4];
    logic [3:0]      dp_out_r;
    logic            frame_valid_r;
    logic            seg_error_r;
    logic            anode_error_r;
    logic [TO_W-1:0] to_cnt_r;
    logic            stale_r;

    assign raw_word_s = {AN4, AN3, AN2, AN1, CG, CF, CE, CD, CC, CB, CA, DP};

    seven_segment_input_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk       (clk),
        .reset     (reset),
        .raw_word  (raw_word_s),
        .sync_word (sync_word_s),
        .accept    (accept_s)
    );

    // Active-high views of the synchronized word and the segment decode
    always_comb begin
        an_act_s  = ~sync_word_s[11:8];
        seg_act_s = ~sync_word_s[7:1];
        dp_lit_s  = ~sync_word_s[0];
        dec_s     = seg_to_hex(seg_act_s);
    end

    // Classify the anode pattern: blanking gap, one digit, or a conflict
    always_comb begin
        an_class_s  = ANODE_NONE;
        digit_idx_s = SEC1;
        case (an_act_s)
            4'b0000: an_class_s = ANODE_NONE;
            4'b0001: begin an_class_s = ANODE_ONE; digit_idx_s = SEC1; end
            4'b0010: begin an_class_s = ANODE_ONE; digit_idx_s = SEC2; end
            4'b0100: begin an_class_s = ANODE_ONE; digit_idx_s = MIN1; end
            4'b1000: begin an_class_s = ANODE_ONE; digit_idx_s = MIN2; end
            default: an_class_s = ANODE_MULTI;
        endcase
    end

    // Turn an accepted slot into a mask bit or an error flag
    always_comb begin
        accept_bit_s = 4'b0000;
        seg_err_s    = 1'b0;
        an_err_s     = 1'b0;
        if (accept_s) begin
            case (an_class_s)
                ANODE_ONE: begin
                    if (dec_s[4]) begin
                        accept_bit_s = 4'b0001 << digit_idx_s;
                    end else begin
                        seg_err_s = 1'b1;
                    end
                end
                ANODE_MULTI: an_err_s = 1'b1;
                default:     accept_bit_s = 4'b0000;
            endcase
        end else begin
            accept_bit_s = 4'b0000;
        end
    end

    // Frame completion; a same-cycle accept starts the next frame's mask
    always_comb begin
        complete_s = (mask_r == 4'b1111);
        if (complete_s) begin
            mask_next_s = accept_bit_s;
        end else begin
            mask_next_s = mask_r | accept_bit_s;
        end
    end

    // Timeout counter restarts the cycle after a published frame
    always_comb begin
        if (frame_valid_r) begin
            to_cnt_next_s = {TO_W{1'b0}};
        end else if (to_cnt_r == TO_MAX) begin
            to_cnt_next_s = to_cnt_r;
        end else begin
            to_cnt_next_s = to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
        end
    end

    // Capture mask register
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_r <= 4'b0000;
        end else begin
            mask_r <= mask_next_s;
        end
    end

    // Per-digit shadow registers; a repeated slot simply overwrites its shadow
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                shadow_r[i] <= 4'h0;
            end
            dp_shadow_r <= 4'b0000;
        end else if (accept_bit_s != 4'b0000) begin
            shadow_r[digit_idx_s]    <= dec_s[3:0];
            dp_shadow_r[digit_idx_s] <= dp_lit_s;
        end
    end

    // Published frame and one-cycle status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                digit_out_r[i] <= 4'h0;
            end
            dp_out_r      <= 4'b0000;
            frame_valid_r <= 1'b0;
            seg_error_r   <= 1'b0;
            anode_error_r <= 1'b0;
        end else begin
            if (complete_s) begin
                for (int i = 0; i < 4; i++) begin
                    digit_out_r[i] <= shadow_r[i];
                end
                dp_out_r <= dp_shadow_r;
            end
            frame_valid_r <= complete_s;
            seg_error_r   <= seg_err_s;
            anode_error_r <= an_err_s;
        end
    end

    // Timeout counter and stale flag (stale mirrors counter saturation)
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_r <= {TO_W{1'b0}};
            stale_r  <= 1'b0;
        end else begin
            to_cnt_r <= to_cnt_next_s;
            stale_r  <= (to_cnt_next_s == TO_MAX);
        end
    end

    assign sec_dig1      = digit_out_r[SEC1];
    assign sec_dig2      = digit_out_r[SEC2];
    assign min_dig1      = digit_out_r[MIN1];
    assign min_dig2      = digit_out_r[MIN2];
    assign decimal_point = dp_out_r;
    assign frame_valid   = frame_valid_r;
    assign seg_error     = seg_error_r;
    assign anode_error   = anode_error_r;
    assign stale         = stale_r;

endmodule

// File: tb/tb_seven_segment_display_capture.sv
// Testbench for seven_segment_display_capture (STABLE_CYCLES=4, TIMEOUT_CYCLES=64).
// A cycle-level model derived from the pin history (run length of each sampled
// word, two-cycle sync delay, frame/timeout rules) is compared with every DUT
// output after each clock edge; directed tests add literal expectations.
module tb_seven_segment_display_capture;

    localparam int S = 4;
    localparam int T = 64;
    localparam logic [11:0] IDLE = 12'hFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [11:0] pins;
    logic CA, CB, CC, CD, CE, CF, CG, DP, AN1, AN2, AN3, AN4;
    logic [3:0] sec_dig1, sec_dig2, min_dig1, min_dig2, decimal_point;
    logic frame_valid, seg_error, anode_error, stale;

    assign {AN4, AN3, AN2, AN1, CG, CF, CE, CD, CC, CB, CA, DP} = pins;

    seven_segment_display_capture #(
        .STABLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk (clk), .reset (reset),
        .CA (CA), .CB (CB), .CC (CC), .CD (CD), .CE (CE), .CF (CF), .CG (CG),
        .DP (DP), .AN1 (AN1), .AN2 (AN2), .AN3 (AN3), .AN4 (AN4),
        .sec_dig1 (sec_dig1), .sec_dig2 (sec_dig2),
        .min_dig1 (min_dig1), .min_dig2 (min_dig2),
        .decimal_point (decimal_point), .frame_valid (frame_valid),
        .seg_error (seg_error), .anode_error (anode_error), .stale (stale)
    );

    // Hex glyphs, gfedcba, 1 = lit
    logic [6:0] pat [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                             7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                             7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                             7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

    int n_cmp = 0;
    int n_bad = 0;
    int fv_seen = 0;
    int se_seen = 0;
    int ae_seen = 0;

    // Model state
    logic [11:0] m_d1, m_d2, m_last, m_w, m_p;
    int          m_run, m_since, m_nlow, m_idx, m_val;
    logic        m_r, m_acc, m_found;
    logic [3:0]  m_mask, m_bits, m_an, m_dsh, m_dp;
    logic [3:0]  m_sh  [4];
    logic [3:0]  m_out [4];
    logic        m_fv, m_se, m_ae, m_stale;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] slot(input int s, input logic [6:0] seg, input logic dp_lit);
        logic [3:0] an;
        an = 4'b1111;
        an[s] = 1'b0;
        return {an, ~seg, ~dp_lit};
    endfunction

    task automatic hold(input logic [11:0] w, input int n);
        pins = w;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        hold(IDLE, n);
        reset = 1'b0;
    endtask

    // Model update on each edge, compare 4 time units later
    initial begin
        forever begin
            @(posedge clk);
            m_r = reset;
            m_p = pins;
            if (m_r) begin
                m_d1 = IDLE; m_d2 = IDLE; m_last = IDLE; m_run = 0;
                m_mask = 4'b0000; m_dsh = 4'b0000; m_dp = 4'b0000;
                for (int i = 0; i < 4; i++) begin m_sh[i] = 4'h0; m_out[i] = 4'h0; end
                m_fv = 1'b0; m_se = 1'b0; m_ae = 1'b0; m_since = 0; m_stale = 1'b0;
            end else begin
                if (m_fv) m_since = 0;
                else if (m_since < T - 1) m_since++;
                m_stale = (m_since == T - 1);
                // word seen by the filter is the pin sample from two edges ago
                if (m_d2 == m_last) m_run++;
                else m_run = 1;
                m_last = m_d2;
                m_acc  = (m_run == S);
                m_w    = m_d2;
                m_d2   = m_d1;
                m_d1   = m_p;
                m_fv = (m_mask == 4'b1111);
                if (m_fv) begin
                    for (int i = 0; i < 4; i++) m_out[i] = m_sh[i];
                    m_dp = m_dsh;
                end
                m_se = 1'b0; m_ae = 1'b0; m_bits = 4'b0000;
                if (m_acc) begin
                    m_an   = ~m_w[11:8];
                    m_nlow = $countones(m_an);
                    if (m_nlow > 1) begin
                        m_ae = 1'b1;
                    end else if (m_nlow == 1) begin
                        m_found = 1'b0; m_val = 0; m_idx = 0;
                        for (int v = 0; v < 16; v++)
                            if (pat[v] == ~m_w[7:1]) begin m_found = 1'b1; m_val = v; end
                        for (int i = 0; i < 4; i++)
                            if (m_an[i]) m_idx = i;
                        if (m_found) begin
                            m_sh[m_idx]  = 4'(m_val);
                            m_dsh[m_idx] = ~m_w[0];
                            m_bits[m_idx] = 1'b1;
                        end else begin
                            m_se = 1'b1;
                        end
                    end
                end
                m_mask = m_fv ? m_bits : (m_mask | m_bits);
            end
            #4;
            chk("sec_dig1", 32'(sec_dig1), 32'(m_out[0]));
            chk("sec_dig2", 32'(sec_dig2), 32'(m_out[1]));
            chk("min_dig1", 32'(min_dig1), 32'(m_out[2]));
            chk("min_dig2", 32'(min_dig2), 32'(m_out[3]));
            chk("decimal_point", 32'(decimal_point), 32'(m_dp));
            chk("frame_valid", 32'(frame_valid), 32'(m_fv));
            chk("seg_error", 32'(seg_error), 32'(m_se));
            chk("anode_error", 32'(anode_error), 32'(m_ae));
            chk("stale", 32'(stale), 32'(m_stale));
            if (frame_valid === 1'b1) fv_seen++;
            if (seg_error === 1'b1) se_seen++;
            if (anode_error === 1'b1) ae_seen++;
        end
    end

    int b_fv, b_se, b_ae;

    initial begin
        pins  = IDLE;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        chk("reset_digits", {sec_dig1, sec_dig2, min_dig1, min_dig2}, 32'h0);
        chk("reset_flags", {decimal_point, frame_valid, seg_error, anode_error, stale}, 32'h0);

        // Basic frame 3,5,9,1 with DP on slot 2
        b_fv = fv_seen;
        hold(slot(0, pat[3], 1'b0), 10);
        hold(slot(1, pat[5], 1'b0), 10);
        hold(slot(2, pat[9], 1'b1), 10);
        hold(slot(3, pat[1], 1'b0), 10);
        hold(IDLE, 8);
        chk("t1_frames", fv_seen - b_fv, 1);
        chk("t1_digits", {sec_dig1, sec_dig2, min_dig1, min_dig2}, 32'h3591);
        chk("t1_dp", decimal_point, 32'b0100);

        // Too-short hold on slot 1 is ignored; later 7 on slot 1 completes
        b_fv = fv_seen;
        hold(slot(0, pat[2], 1'b0), 10);
        hold(slot(2, pat[6], 1'b0), 10);
        hold(slot(3, pat[4], 1'b0), 10);
        hold(slot(1, pat[8], 1'b0), 3);
        hold(IDLE, 10);
        chk("t2_short_no_frame", fv_seen - b_fv, 0);
        hold(slot(1, pat[7], 1'b0), 10);
        hold(IDLE, 8);
        chk("t2_frames", fv_seen - b_fv, 1);
        chk("t2_digits", {sec_dig1, sec_dig2, min_dig1, min_dig2}, 32'h2764);
        chk("t2_dp", decimal_point, 32'b0000);

        // Undecodable glyph on slot 2, then a valid frame with 8 on slot 2
        b_fv = fv_seen; b_se = se_seen;
        hold(slot(2, 7'b1010101, 1'b0), 10);
        hold(IDLE, 8);
        chk("t3_seg_error", se_seen - b_se, 1);
        chk("t3_no_frame", fv_seen - b_fv, 0);
        hold(slot(0, pat[10], 1'b0), 10);
        hold(slot(1, pat[11], 1'b0), 10);
        hold(slot(2, pat[8], 1'b0), 10);
        hold(slot(3, pat[15], 1'b0), 10);
        hold(IDLE, 8);
        chk("t3_frames", fv_seen - b_fv, 1);
        chk("t3_digits", {sec_dig1, sec_dig2, min_dig1, min_dig2}, 32'hAB8F);

        // AN1+AN3 together: one anode_error, mask untouched, idle gives nothing
        b_fv = fv_seen; b_se = se_seen; b_ae = ae_seen;
        hold(slot(1, pat[0], 1'b0), 10);
        hold({4'b1010, ~pat[0], 1'b1}, 10);
        hold(IDLE, 20);
        chk("t4_anode_error", ae_seen - b_ae, 1);
        chk("t4_no_seg_error", se_seen - b_se, 0);
        chk("t4_no_frame", fv_seen - b_fv, 0);
        hold(slot(3, pat[3], 1'b0), 10);
        hold(slot(2, pat[5], 1'b0), 10);
        hold(IDLE, 8);
        chk("t4_slot0_missing", fv_seen - b_fv, 0);
        hold(slot(0, pat[9], 1'b0), 10);
        hold(IDLE, 8);
        chk("t4_frames", fv_seen - b_fv, 1);
        chk("t4_digits", {sec_dig1, sec_dig2, min_dig1, min_dig2}, 32'h9053);

        // Timeout: stale after 64 idle cycles, cleared by the next frame
        do_reset(3);
        hold(IDLE, 40);
        chk("t5_not_stale_yet", stale, 32'h0);
        hold(IDLE, 30);
        chk("t5_stale", stale, 32'h1);
        b_fv = fv_seen;
        hold(slot(0, pat[5], 1'b1), 10);
        hold(slot(1, pat[6], 1'b0), 10);
        hold(slot(2, pat[7], 1'b0), 10);
        hold(slot(3, pat[8], 1'b0), 10);
        hold(IDLE, 5);
        chk("t5_frames", fv_seen - b_fv, 1);
        chk("t5_stale_cleared", stale, 32'h0);
        chk("t5_digits", {sec_dig1, sec_dig2, min_dig1, min_dig2}, 32'h5678);
        chk("t5_dp", decimal_point, 32'b0001);

        // Reset with a partial mask discards it
        hold(slot(0, pat[1], 1'b0), 10);
        hold(slot(1, pat[2], 1'b0), 10);
        hold(slot(2, pat[3], 1'b0), 10);
        hold(IDLE, 2);
        do_reset(3);
        chk("t6_digits_zero", {sec_dig1, sec_dig2, min_dig1, min_dig2}, 32'h0);
        chk("t6_dp_zero", decimal_point, 32'h0);
        b_fv = fv_seen;
        hold(slot(3, pat[4], 1'b0), 10);
        hold(IDLE, 10);
        chk("t6_no_frame", fv_seen - b_fv, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
